// File: rtl/hdmi_link_seq.sv
// -----------------------------------------------------------------------------
// hdmi_link_seq
//
// Bring-up sequencer for an HDMI transmit link. It waits for the pixel PLL to
// lock, lets the lock settle, releases the /5 clock divider, optionally checks
// the resulting pixel clock rate, and finally releases the HDMI encoder. Lock
// loss or a bad pixel-clock window triggers a retry. Too many retries, or a
// lock timeout, parks the sequencer in FAULT until enable is dropped.
//
// Build option:
//   HDMI_SEQ_CLKMON_EN  defined   -> pixel-clock monitor and CLK_CHECK state
//                                    are compiled in.
//                       undefined -> DIV_RUN goes straight to RUN, pix_tog is
//                                    ignored, and RUN exits only on lock loss.
//
// Ports:
//   sys_clk     in   system clock (27 MHz)
//   sys_resetn  in   asynchronous active-low reset
//   enable      in   link request, synchronous to sys_clk
//   pll_lock    in   PLL lock indication, asynchronous
//   pix_tog     in   toggles once per 64 pixel clocks, asynchronous
//   div_resetn  out  active-low reset to the /5 clock divider
//   hdmi_reset  out  active-high reset to the HDMI encoder
//   link_up     out  high only in RUN
//   fault       out  high only in FAULT
//   state       out  current state encoding (OFF=0 .. FAULT=6)
//   retry_cnt   out  failed bring-up count, saturating at 15
// -----------------------------------------------------------------------------
module hdmi_link_seq #(
    parameter int LOCK_TIMEOUT    = 2700000,
    parameter int LOCK_SETTLE_CYC = 2700,
    parameter int DIV_SETTLE_CYC  = 64,
    parameter int WINDOW_CYC      = 2700,
    parameter int PIX_MIN         = 110,
    parameter int PIX_MAX         = 122,
    parameter int MAX_RETRY       = 3
) (
    input  logic       sys_clk,
    input  logic       sys_resetn,
    input  logic       enable,
    input  logic       pll_lock,
    input  logic       pix_tog,
    output logic       div_resetn,
    output logic       hdmi_reset,
    output logic       link_up,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_SETTLE = 3'd2,
        ST_DIV_RUN     = 3'd3,
        ST_CLK_CHECK   = 3'd4,
        ST_RUN         = 3'd5,
        ST_FAULT       = 3'd6,
        ST_BAD         = 3'd7
    } state_t;

    // One shared cycle counter serves the lock timeout, the lock settle time
    // and the divider settle time, so it is sized for the largest of them.
    localparam int CNT_MAX =
        (LOCK_TIMEOUT > LOCK_SETTLE_CYC) ?
            ((LOCK_TIMEOUT > DIV_SETTLE_CYC) ? LOCK_TIMEOUT : DIV_SETTLE_CYC) :
            ((LOCK_SETTLE_CYC > DIV_SETTLE_CYC) ? LOCK_SETTLE_CYC : DIV_SETTLE_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LOCK_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DS_LAST  = CNT_W'(DIV_SETTLE_CYC - 1);
    localparam logic [31:0]      MAX_RETRY_U = MAX_RETRY;

    // Saturating increment for the 4-bit retry counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = 4'hF;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       retry_r;
    logic [3:0]       retry_nxt_s;
    logic [3:0]       retry_inc_s;
    logic             retry_fault_s;
    logic             retry_req_s;
    logic [1:0]       lock_sync_r;
    logic             lock_s;
    logic             div_resetn_r;
    logic             hdmi_reset_r;
    logic             link_up_r;
    logic             fault_r;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            lock_sync_r <= 2'b00;
        end else begin
            lock_sync_r <= {lock_sync_r[0], pll_lock};
        end
    end

    assign lock_s = lock_sync_r[1];

`ifdef HDMI_SEQ_CLKMON_EN
    // Edge counter must be able to represent PIX_MAX+1 so that "too many"
    // is distinguishable from "exactly PIX_MAX".
    localparam int EDGE_W = $clog2(PIX_MAX + 2);
    localparam int WIN_W  = $clog2(WINDOW_CYC + 1);

    localparam logic [EDGE_W-1:0] EDGE_ZERO = EDGE_W'(0);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
    localparam logic [EDGE_W-1:0] EDGE_SAT  = {EDGE_W{1'b1}};
    localparam logic [EDGE_W-1:0] EDGE_MIN  = EDGE_W'(PIX_MIN);
    localparam logic [EDGE_W-1:0] EDGE_MAX  = EDGE_W'(PIX_MAX);
    localparam logic [WIN_W-1:0]  WIN_ZERO  = WIN_W'(0);
    localparam logic [WIN_W-1:0]  WIN_ONE   = WIN_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYC - 1);

    logic [1:0]        pix_sync_r;
    logic              pix_prev_r;
    logic [WIN_W-1:0]  win_cnt_r;
    logic [EDGE_W-1:0] edge_cnt_r;
    logic              pix_edge_s;
    logic              mon_active_s;
    logic              win_end_s;
    logic              in_range_s;
    logic [EDGE_W-1:0] edge_total_s;

    // Two-flop synchronizer for pix_tog plus a delay flop for edge detection.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            pix_sync_r <= 2'b00;
            pix_prev_r <= 1'b0;
        end else begin
            pix_sync_r <= {pix_sync_r[0], pix_tog};
            pix_prev_r <= pix_sync_r[1];
        end
    end

    // Window bookkeeping: the edge seen in the last cycle of a window still
    // belongs to that window, so the pass test uses the updated total.
    always_comb begin
        mon_active_s = (state_r == ST_CLK_CHECK) || (state_r == ST_RUN);
        pix_edge_s   = pix_sync_r[1] ^ pix_prev_r;
        win_end_s    = mon_active_s && (win_cnt_r == WIN_LAST);
        if (pix_edge_s && (edge_cnt_r != EDGE_SAT)) begin
            edge_total_s = edge_cnt_r + EDGE_ONE;
        end else begin
            edge_total_s = edge_cnt_r;
        end
        in_range_s = (edge_total_s >= EDGE_MIN) && (edge_total_s <= EDGE_MAX);
    end

    // Window and edge counters: held at zero outside CLK_CHECK/RUN and
    // restarted at every window boundary so windows run back-to-back.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            win_cnt_r  <= WIN_ZERO;
            edge_cnt_r <= EDGE_ZERO;
        end else if (!mon_active_s || win_end_s) begin
            win_cnt_r  <= WIN_ZERO;
            edge_cnt_r <= EDGE_ZERO;
        end else begin
            win_cnt_r  <= win_cnt_r + WIN_ONE;
            edge_cnt_r <= edge_total_s;
        end
    end
`else
    // Monitor not built: keep the monitor inputs and parameters referenced.
    localparam int CLKMON_UNUSED = WINDOW_CYC + PIX_MIN + PIX_MAX;
    logic [31:0] clkmon_unused_s;
    assign clkmon_unused_s = {31'd0, pix_tog} ^ CLKMON_UNUSED[31:0];
`endif

    // Retry outcome, computed once for every state that can request a retry.
    always_comb begin
        retry_inc_s   = sat_inc4(retry_r);
        retry_fault_s = ({28'd0, retry_inc_s} >= MAX_RETRY_U);
    end

    // Next-state logic; enable=0 overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        retry_nxt_s = retry_r;
        retry_req_s = 1'b0;
        if (!enable) begin
            state_nxt_s = ST_OFF;
            cnt_nxt_s   = CNT_ZERO;
            retry_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_nxt_s = ST_WAIT_LOCK;
                    cnt_nxt_s   = CNT_ZERO;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt_s = ST_LOCK_SETTLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == LT_LAST) begin
                        state_nxt_s = ST_FAULT;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_LOCK_SETTLE: begin
                    if (!lock_s) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == LS_LAST) begin
                        state_nxt_s = ST_DIV_RUN;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_DIV_RUN: begin
                    if (!lock_s) begin
                        retry_req_s = 1'b1;
                    end else if (cnt_r == DS_LAST) begin
`ifdef HDMI_SEQ_CLKMON_EN
                        state_nxt_s = ST_CLK_CHECK;
`else
                        state_nxt_s = ST_RUN;
`endif
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_CLK_CHECK: begin
`ifdef HDMI_SEQ_CLKMON_EN
                    if (!lock_s) begin
                        retry_req_s = 1'b1;
                    end else if (win_end_s) begin
                        if (in_range_s) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            retry_req_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_CLK_CHECK;
                    end
`else
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = CNT_ZERO;
`endif
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        retry_req_s = 1'b1;
`ifdef HDMI_SEQ_CLKMON_EN
                    end else if (win_end_s && !in_range_s) begin
                        retry_req_s = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_nxt_s = ST_FAULT;
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
            if (retry_req_s) begin
                retry_nxt_s = retry_inc_s;
                cnt_nxt_s   = CNT_ZERO;
                if (retry_fault_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end else begin
                retry_nxt_s = retry_r;
            end
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state register.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_r      <= ST_OFF;
            cnt_r        <= CNT_ZERO;
            retry_r      <= 4'd0;
            div_resetn_r <= 1'b0;
            hdmi_reset_r <= 1'b1;
            link_up_r    <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            retry_r      <= retry_nxt_s;
            div_resetn_r <= (state_nxt_s == ST_DIV_RUN) ||
                            (state_nxt_s == ST_CLK_CHECK) ||
                            (state_nxt_s == ST_RUN);
            hdmi_reset_r <= (state_nxt_s != ST_RUN);
            link_up_r    <= (state_nxt_s == ST_RUN);
            fault_r      <= (state_nxt_s == ST_FAULT);
        end
    end

    assign state      = state_r;
    assign retry_cnt  = retry_r;
    assign div_resetn = div_resetn_r;
    assign hdmi_reset = hdmi_reset_r;
    assign link_up    = link_up_r;
    assign fault      = fault_r;

endmodule

// File: doc/hdmi_link_seq.md
HDMI_LINK_SEQ -- requirements
Module: hdmi_link_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 2700000; sys_clk cycles allowed in WAIT_LOCK before fault (100 ms at 27 MHz).
REQ-002 SHALL have parameter LOCK_SETTLE_CYC, default 2700; consecutive cycles of synced lock required before releasing the divider.
REQ-003 SHALL have parameter DIV_SETTLE_CYC, default 64; cycles divider runs before the clock check.
REQ-004 SHALL have parameter WINDOW_CYC, default 2700; pixel-clock measurement window in sys_clk cycles.
REQ-005 SHALL have parameters PIX_MIN, default 110, and PIX_MAX, default 122; inclusive pix_tog edge-count pass range per window.
REQ-006 SHALL have parameter MAX_RETRY, default 3; failed bring-ups tolerated before FAULT.
REQ-007 sys_clk  in  1  system clock, 27 MHz.
REQ-008 sys_resetn  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  link request; synchronous to sys_clk.
REQ-010 pll_lock  in  1  PLL lock, asynchronous.
REQ-011 pix_tog  in  1  asynchronous; toggles once per 64 clk_pixel cycles.
REQ-012 div_resetn  out  1  active-low reset to the /5 clock divider.
REQ-013 hdmi_reset  out  1  active-high reset to the HDMI encoder.
REQ-014 link_up  out  1  high only in RUN.
REQ-015 fault  out  1  high only in FAULT.
REQ-016 state  out  3  current state encoding.
REQ-017 retry_cnt  out  4  failed-attempt count; saturates at 15.

Function
REQ-018 pll_lock and pix_tog SHALL each pass through a 2-flop synchronizer; 2-cycle latency to internal use.
REQ-019 Each change of synced pix_tog SHALL count as one edge.
REQ-020 States, encoding: OFF=0, WAIT_LOCK=1, LOCK_SETTLE=2, DIV_RUN=3, CLK_CHECK=4, RUN=5, FAULT=6; 7 unreachable, recovers to OFF.
REQ-021 All outputs SHALL be registered and update on the same edge as the state register.
REQ-022 div_resetn=1 only in DIV_RUN, CLK_CHECK, RUN; hdmi_reset=0 only in RUN.
REQ-023 enable=0 in any state SHALL force OFF on the next edge and clear retry_cnt; this takes priority over all other transitions.
REQ-024 OFF: enable=1 -> WAIT_LOCK; cycle counter cleared.
REQ-025 WAIT_LOCK: lock_s=1 -> LOCK_SETTLE. LOCK_TIMEOUT cycles elapsed without lock -> FAULT.
REQ-026 LOCK_SETTLE: lock_s=0 -> WAIT_LOCK, timeout counter restarted. LOCK_SETTLE_CYC consecutive lock_s=1 cycles -> DIV_RUN.
REQ-027 DIV_RUN: after DIV_SETTLE_CYC cycles -> CLK_CHECK. lock_s=0 -> retry.
REQ-028 CLK_CHECK: window of exactly WINDOW_CYC cycles, edge counter cleared at entry.
REQ-029 CLK_CHECK: count in [PIX_MIN,PIX_MAX] at window end -> RUN. Out of range -> retry. lock_s=0 -> retry immediately.
REQ-030 RUN: lock_s=0 -> retry. Windows repeat back-to-back; any window out of range -> retry.
REQ-031 Retry SHALL increment retry_cnt (saturating). If the new value is >= MAX_RETRY -> FAULT; else -> WAIT_LOCK.
REQ-032 retry_cnt SHALL NOT clear on successful entry to RUN.
REQ-033 FAULT SHALL be exited only via enable=0.
REQ-034 Edge counter SHALL saturate at its maximum rather than wrap; width SHALL hold PIX_MAX+1.

Reset
REQ-035 While sys_resetn=0: state=OFF, div_resetn=0, hdmi_reset=1, link_up=0, fault=0, retry_cnt=0.
REQ-036 While sys_resetn=0, all counters and synchronizer flops SHALL be 0.
REQ-037 Deassertion mid-operation SHALL always restart from OFF; no state is retained.

Configuration
REQ-038 Macro HDMI_SEQ_CLKMON_EN defined: pixel-clock monitor, edge counter and CLK_CHECK are compiled in, as specified above.
REQ-039 Macro HDMI_SEQ_CLKMON_EN undefined: DIV_RUN goes directly to RUN; RUN exits only on lock loss; pix_tog is ignored; state value 4 is never produced.

Verification
REQ-040 Reset, enable=1, pll_lock rises at cycle 100 -> state 1->2->3->4->5, with 1.16 MHz pix_tog; link_up=1 after about 100+2+2700+64+2700 cycles.
REQ-041 In RUN, drop pix_tog rate to 0.5 MHz (about 50 edges/window) -> retry_cnt=1, state=1, hdmi_reset=1 and div_resetn=0 on the next edge after the window ends.
REQ-042 pll_lock never rises -> FAULT after 2700000 cycles, fault=1; enable=0 -> OFF next edge, fault=0.
REQ-043 pll_lock glitches low for 1 cycle at cycle 1000 of LOCK_SETTLE -> back to WAIT_LOCK; the settle count restarts from 0.
REQ-044 Three consecutive out-of-range windows (count 130) -> retry_cnt=3, state=6.
REQ-045 sys_resetn pulsed low while in RUN -> all outputs take their reset values asynchronously; bring-up repeats from OFF.
